// File: rtl/dcp_data_dump.sv
// rtl/dcp_data_dump.sv - debug panel 'D' handler: dumps an address and eight data words over the UART
module dcp_data_dump (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sel_mode,
  input  logic [7:0]  CMD_D,
  output logic        finish_D,
  output logic [31:0] addr_D,
  input  logic [31:0] din_rx,
  input  logic [31:0] dout_dm,
  input  logic        ack_rx,
  input  logic        flag_rx,
  input  logic        ack_tx,
  output logic        req_rx_D,
  output logic        type_rx_D,
  output logic        req_tx_D,
  output logic        type_tx_D,
  output logic [31:0] dout_D
);

  typedef enum logic [3:0] {
    IDLE, SCAN, INF1, INF2, ADDR, COLON, DATA, CR, LF, DONE, HOLD
  } state_t;

  state_t      state, state_n;
  logic        req, req_n;
  logic [31:0] cur, last;
  logic [2:0]  cnt;
  logic        tx_state, rx_hit, tx_hit;

  always_comb begin
    tx_state = (state == INF1) || (state == INF2) || (state == ADDR) || (state == COLON) ||
               (state == DATA) || (state == CR) || (state == LF);
    rx_hit   = req && (state == SCAN) && ack_rx;
    tx_hit   = req && tx_state && ack_tx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req   <= 1'b0;
    end else begin
      state <= state_n;
      req   <= req_n;
    end
  end

  // The request register is cleared on every consumed ack, so each new
  // request starts one idle cycle after the previous handshake.
  always_comb begin
    state_n   = state;
    req_n     = 1'b0;
    finish_D  = 1'b0;
    type_tx_D = 1'b0;
    dout_D    = 32'h0;
    if ((state == SCAN) || tx_state)
      req_n = !(rx_hit || tx_hit);
    case (state)
      IDLE:  if (sel_mode == CMD_D) state_n = SCAN;
      SCAN:  if (rx_hit) state_n = INF1;
      INF1: begin
        dout_D = 32'h0D;
        if (tx_hit) state_n = INF2;
      end
      INF2: begin
        dout_D = 32'h0A;
        if (tx_hit) state_n = ADDR;
      end
      ADDR: begin
        type_tx_D = 1'b1;
        dout_D    = cur;
        if (tx_hit) state_n = COLON;
      end
      COLON: begin
        dout_D = 32'h3A;
        if (tx_hit) state_n = DATA;
      end
      DATA: begin
        type_tx_D = 1'b1;
        dout_D    = dout_dm;
        if (tx_hit && (cnt == 3'd7)) state_n = CR;
      end
      CR: begin
        dout_D = 32'h0D;
        if (tx_hit) state_n = LF;
      end
      LF: begin
        dout_D = 32'h0A;
        if (tx_hit) state_n = DONE;
      end
      DONE: begin
        finish_D = 1'b1;
        state_n  = HOLD;
      end
      HOLD:  if (sel_mode != CMD_D) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur  <= 32'h0;
      last <= 32'h0;
      cnt  <= 3'd0;
    end else if (rx_hit) begin
      cur <= flag_rx ? din_rx : last;
    end else if (tx_hit) begin
      if (state == COLON) cnt <= 3'd0;
      if (state == DATA) begin
        cur <= cur + 32'd1;
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) last <= cur + 32'd1;
      end
    end
  end

  assign addr_D    = cur;
  assign req_rx_D  = req && (state == SCAN);
  assign req_tx_D  = req && tx_state;
  assign type_rx_D = 1'b1;

endmodule

// File: tb/tb_dcp_data_dump.sv
// tb/tb_dcp_data_dump.sv - randomized self-checking bench for dcp_data_dump
module tb_dcp_data_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sel_mode;
  logic [7:0]  CMD_D = 8'h44;
  logic        finish_D;
  logic [31:0] addr_D;
  logic [31:0] din_rx;
  logic [31:0] dout_dm;
  logic        ack_rx, flag_rx, ack_tx;
  logic        req_rx_D, type_rx_D, req_tx_D, type_tx_D;
  logic [31:0] dout_D;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_last = 32'h0;
  bit          use_const = 1'b1;

  dcp_data_dump dut (
    .clk(clk), .rst(rst), .sel_mode(sel_mode), .CMD_D(CMD_D), .finish_D(finish_D),
    .addr_D(addr_D), .din_rx(din_rx), .dout_dm(dout_dm), .ack_rx(ack_rx), .flag_rx(flag_rx),
    .ack_tx(ack_tx), .req_rx_D(req_rx_D), .type_rx_D(type_rx_D), .req_tx_D(req_tx_D),
    .type_tx_D(type_tx_D), .dout_D(dout_D)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return use_const ? 32'h716 : ((a * 32'h9E3779B1) ^ 32'h0F0F1234);
  endfunction

  always_comb dout_dm = mem_val(addr_D);

  // One complete dump; the expected line is built from the start address alone.
  task automatic run_dump(input bit flag, input logic [31:0] din, input int stall_idx, input int abort_at);
    logic [31:0] start, snap_d, snap_a;
    logic [31:0] exp_d[14];
    bit          exp_t[14];
    bit          ok, snap_t;
    int          d;
    start = flag ? din : model_last;
    exp_t[0] = 0; exp_d[0] = 32'h0D;
    exp_t[1] = 0; exp_d[1] = 32'h0A;
    exp_t[2] = 1; exp_d[2] = start;
    exp_t[3] = 0; exp_d[3] = 32'h3A;
    for (int i = 0; i < 8; i++) begin
      exp_t[4+i] = 1;
      exp_d[4+i] = mem_val(start + i);
    end
    exp_t[12] = 0; exp_d[12] = 32'h0D;
    exp_t[13] = 0; exp_d[13] = 32'h0A;

    sel_mode = 8'h00;
    repeat (2) @(negedge clk);
    sel_mode = 8'h44;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (req_rx_D === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rx_req_timeout actual=%b required=1", req_rx_D);
      return;
    end
    checks++;
    if (type_rx_D !== 1'b1) begin
      errors++;
      $display("FAIL type_rx actual=%b required=1", type_rx_D);
    end
    flag_rx = flag; din_rx = din; ack_rx = 1'b1;
    @(negedge clk);
    ack_rx = 1'b0; flag_rx = 1'b0; din_rx = $urandom;
    checks++;
    if (req_rx_D !== 1'b0) begin
      errors++;
      $display("FAIL rx_req_drop actual=%b required=0", req_rx_D);
    end

    for (int k = 0; k < 14; k++) begin
      ok = 0;
      for (int i = 0; i < 50; i++) begin
        if (req_tx_D === 1'b1) begin ok = 1; break; end
        @(negedge clk);
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL tx_req_timeout[%0d] actual=%b required=1", k, req_tx_D);
        return;
      end
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({req_rx_D, req_tx_D, finish_D} !== 3'b000 || addr_D !== 32'h0) begin
          errors++;
          $display("FAIL reset_mid actual=req_rx %b req_tx %b fin %b addr %h required=0 0 0 0",
                   req_rx_D, req_tx_D, finish_D, addr_D);
        end
        model_last = 32'h0;
        return;
      end
      checks++;
      if (type_tx_D !== exp_t[k] || dout_D !== exp_d[k]) begin
        errors++;
        $display("FAIL tx_payload[%0d] actual=type %b data %h required=type %b data %h",
                 k, type_tx_D, dout_D, exp_t[k], exp_d[k]);
      end
      if (k >= 4 && k < 12) begin
        checks++;
        if (addr_D !== start + (k - 4)) begin
          errors++;
          $display("FAIL addr_data[%0d] actual=%h required=%h", k - 4, addr_D, start + (k - 4));
        end
      end
      d = (k == stall_idx) ? 20 : $urandom_range(0, 3);
      snap_d = dout_D; snap_a = addr_D; snap_t = type_tx_D;
      repeat (d) begin
        @(negedge clk);
        checks++;
        if (req_tx_D !== 1'b1 || dout_D !== snap_d || addr_D !== snap_a || type_tx_D !== snap_t) begin
          errors++;
          $display("FAIL stall_stable[%0d] actual=req %b data %h addr %h type %b required=1 %h %h %b",
                   k, req_tx_D, dout_D, addr_D, type_tx_D, snap_d, snap_a, snap_t);
        end
      end
      ack_tx = 1'b1;
      @(negedge clk);
      ack_tx = 1'b0;
      checks++;
      if (req_tx_D !== 1'b0 || (k < 13 && finish_D !== 1'b0)) begin
        errors++;
        $display("FAIL tx_req_drop[%0d] actual=req %b fin %b required=0 0", k, req_tx_D, finish_D);
      end
    end
    checks++;
    if (finish_D !== 1'b1) begin
      errors++;
      $display("FAIL finish_rise actual=%b required=1", finish_D);
    end
    @(negedge clk);
    checks++;
    if (finish_D !== 1'b0) begin
      errors++;
      $display("FAIL finish_pulse actual=%b required=0", finish_D);
    end
    model_last = start + 32'd8;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({finish_D, req_rx_D, req_tx_D, type_tx_D} !== 4'b0000 || addr_D !== 32'h0 ||
        dout_D !== 32'h0 || type_rx_D !== 1'b1) begin
      errors++;
      $display("FAIL reset_values actual=fin %b rrx %b rtx %b ttx %b addr %h dout %h trx %b required=0 0 0 0 0 0 1",
               finish_D, req_rx_D, req_tx_D, type_tx_D, addr_D, dout_D, type_rx_D);
    end
    rst = 1'b0;
  endtask

  task automatic test_hold;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if (req_rx_D !== 1'b0 || req_tx_D !== 1'b0 || finish_D !== 1'b0) begin
        errors++;
        $display("FAIL hold_no_rescan[%0d] actual=rrx %b rtx %b fin %b required=0 0 0",
                 i, req_rx_D, req_tx_D, finish_D);
      end
    end
  endtask

  task automatic test_other_mode;
    sel_mode = 8'h4D;
    for (int i = 0; i < 30; i++) begin
      ack_tx = 1'($urandom_range(0, 1));
      ack_rx = 1'($urandom_range(0, 1));
      flag_rx = 1'b1; din_rx = $urandom;
      @(negedge clk);
      checks++;
      if (req_rx_D !== 1'b0 || req_tx_D !== 1'b0 || finish_D !== 1'b0) begin
        errors++;
        $display("FAIL other_mode[%0d] actual=rrx %b rtx %b fin %b required=0 0 0",
                 i, req_rx_D, req_tx_D, finish_D);
      end
    end
    ack_tx = 1'b0; ack_rx = 1'b0; flag_rx = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel_mode = 8'h00; din_rx = 32'h0;
    ack_rx = 1'b0; flag_rx = 1'b0; ack_tx = 1'b0;
    @(negedge clk);
    test_reset;
    run_dump(1'b0, 32'h0, -1, -1);
    test_hold;
    use_const = 1'b0;
    run_dump(1'b1, 32'h123, -1, -1);
    run_dump(1'b0, 32'h0, -1, -1);
    test_other_mode;
    run_dump(1'b0, 32'h0, 6, -1);
    run_dump(1'b1, 32'hFFFF_FFFC, -1, -1);
    run_dump(1'b0, 32'h0, -1, -1);
    for (int r = 0; r < 5; r++)
      run_dump(1'($urandom_range(0, 1)), $urandom, -1, -1);
    run_dump(1'b1, 32'h5000, -1, 7);
    run_dump(1'b0, 32'h0, -1, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcp_data_dump.md
# dcp_data_dump

Debug-control-panel handler for the serial debug unit's `D` (dump data memory) command. When the command decoder selects `D`, the block:

- optionally reads a start address from the UART receiver;
- prints one line showing the address followed by eight consecutive data-memory words, through the UART transmitter;
- pulses `finish_D` when the line is complete.

Without an entered address, the dump continues from where the previous dump ended.

## Interface
Parameters: none.

Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.

- `clk` input 1: system clock, all state changes on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sel_mode` input 8: currently selected command character.
- `CMD_D` input 8: this handler's command code (0x44, `D`). The block is active while `sel_mode == CMD_D`.
- `finish_D` output 1: one-cycle pulse when the dump line is complete.
- `addr_D` output 32: word address presented to the CPU data memory.
- `din_rx` input 32: hex value parsed by the receiver.
- `dout_dm` input 32: data-memory read data for `addr_D` (combinational read).
- `ack_rx` input 1: receiver completion pulse, one cycle.
- `flag_rx` input 1: valid with `ack_rx`. 1 = a number was entered; 0 = empty input.
- `ack_tx` input 1: transmitter completion pulse, one cycle.
- `req_rx_D` output 1: receive request (level).
- `type_rx_D` output 1: receive type. Always 1 = parse hex word.
- `req_tx_D` output 1: transmit request (level).
- `type_tx_D` output 1: transmit type. 0 = send `dout_D[7:0]` as a raw byte; 1 = send `dout_D` as 8 hex digits (separator formatting is the transmitter's job).
- `dout_D` output 32: transmit payload.

## Operation
Internal registers:
- `cur`: 32-bit current address.
- `last`: 32-bit next-dump address, reset 0.
- 3-bit data counter.

State sequence:
- **IDLE**: while `sel_mode == CMD_D`, go to SCAN.
- **SCAN**: `req_rx_D=1`, `type_rx_D=1`. On `ack_rx`:
  - `cur = flag_rx ? din_rx : last`;
  - go to INF1.
- **INF1**: `req_tx_D=1`, type 0, `dout_D=0x0D`. On `ack_tx` go to INF2.
- **INF2**: type 0, `dout_D=0x0A`. On `ack_tx` go to ADDR.
- **ADDR**: type 1, `dout_D=cur`. On `ack_tx` go to COLON.
- **COLON**: type 0, `dout_D=0x3A`. On `ack_tx` go to DATA, with counter = 0.
- **DATA**: type 1, `dout_D=dout_dm`. On `ack_tx`:
  - `cur = cur+1`, counter +1;
  - after the 8th word, set `last = cur+1` (the incremented address) and go to CR.
- **CR**: type 0, `dout_D=0x0D`. On `ack_tx` go to LF.
- **LF**: type 0, `dout_D=0x0A`. On `ack_tx` go to DONE.
- **DONE**: `finish_D=1` for exactly one cycle. Then wait in HOLD until `sel_mode != CMD_D`, then go to IDLE.

Address rules:
- `addr_D` always equals `cur`.
- Addresses are word indices, incremented by 1 with 32-bit wrap (0xFFFFFFFF → 0).

If `sel_mode` leaves `CMD_D` mid-sequence, the sequence still completes. The command decoder does not change mode before `finish_D`.

## Timing
- Reset values:
  - all outputs 0, except `type_rx_D`, which is 1 constant;
  - state IDLE; `cur`, `last` and counter all 0.
- IDLE→SCAN takes 1 cycle; `req_rx_D` is asserted the cycle after entering SCAN.
- Request handshake:
  - Each request is a level held until the matching ack is sampled high on a rising edge.
  - Request, type and `dout_D` are stable for the whole request.
  - On the ack edge the request drops for at least one cycle before the next request rises.
  - Exactly one ack is consumed per state.
  - An ack arriving while no request of that kind is asserted is ignored.
- `dout_D` in DATA tracks `dout_dm` combinationally for the current `cur`. It must be stable during the request because `cur` changes only on ack.
- `finish_D` rises the cycle after the LF ack.
- Minimum duration of a full dump: 14 tx handshakes plus 1 rx handshake plus about 2 cycles per handshake.
- Reset asserted mid-sequence returns to IDLE the next edge. All requests drop and `last` clears to 0.

## Test plan
- Reset, then `sel_mode=0x44`, `flag_rx=0`, `dout_dm=0x716`, `ack_rx` pulse, then 14 `ack_tx` pulses:
  - tx payloads in order: 0x0D, 0x0A, 0x00000000(type1), 0x3A, 8× 0x716(type1), 0x0D, 0x0A;
  - `addr_D` steps 0..7 during DATA;
  - `finish_D` pulses once.
- Second dump with `flag_rx=1`, `din_rx=0x123`:
  - address word printed is 0x123;
  - `addr_D` runs 0x123..0x12A;
  - afterwards `last = 0x12B`.
- Third dump with `flag_rx=0`: printed address is 0x12B.
- `sel_mode=0x4D`:
  - no requests are asserted and `finish_D` stays 0;
  - after a completed dump with `sel_mode` held at 0x44, no new SCAN occurs until `sel_mode` changes.
- Hold `ack_tx` low for 20 cycles in DATA: `req_tx_D`, `type_tx_D`, `dout_D` and `addr_D` stay constant.
- Assert `rst` during DATA:
  - next cycle all requests are 0 and state is IDLE;
  - the next dump with `flag_rx=0` starts at address 0.
